// File: rtl/mult_arbiter.sv
// Arbitrates N_REQ requesters onto one shared multiplier. It uses fixed priority by
// default; define MULT_ARBITER_RR_EN to switch to round-robin arbitration.
package mult_arbiter_pkg;
  localparam int dp_width = 8;
endpackage

module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DP_WIDTH = dp_width
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DP_WIDTH-1:0]   req_multiplicand,
  input  logic [N_REQ*DP_WIDTH-1:0]   req_multiplier,
  output logic [N_REQ-1:0]            ack,
  output logic [2*DP_WIDTH-1:0]       product,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        m_start,
  output logic [DP_WIDTH-1:0]         m_multiplicand,
  output logic [DP_WIDTH-1:0]         m_multiplier,
  input  logic                        m_rdy,
  input  logic [2*DP_WIDTH-1:0]       m_product,
  output logic [2:0]                  dbg_state
);

  localparam int GW = $clog2(N_REQ);

  // Handshake: a requester holds req[i] (operands may change freely) until ack[i];
  // the multiplier takes m_start as a one-cycle command, drops m_rdy while working
  // and raises it alongside a valid m_product.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [DP_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DP_WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*DP_WIDTH-1:0] product_q, product_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic                  m_start_q, m_start_d;
  logic                  busy_q, busy_d;
  logic [GW-1:0]         win;

  // First set request bit found when scanning upward from start, with wrap.
  function automatic logic [GW-1:0] pick(input logic [N_REQ-1:0] r,
                                         input logic [GW-1:0]    start);
    logic [GW-1:0] w;
    logic [GW-1:0] idx;
    w = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(start) + k) % N_REQ);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

`ifdef MULT_ARBITER_RR_EN
  logic [GW-1:0] ptr_q, ptr_d;
  assign win = pick(req, ptr_q);
`else
  assign win = pick(req, '0);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    ack_d     = '0;
`ifdef MULT_ARBITER_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d  = win;
          mcand_d  = req_multiplicand[win*DP_WIDTH +: DP_WIDTH];
          mplier_d = req_multiplier[win*DP_WIDTH +: DP_WIDTH];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      // m_rdy may still show the previous result here, so it is not looked at.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (m_rdy) begin
          product_d      = m_product;
          ack_d[grant_q] = 1'b1;
          state_d        = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
`ifdef MULT_ARBITER_RR_EN
        ptr_d   = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    m_start_d = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      ack_q     <= '0;
      m_start_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MULT_ARBITER_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      ack_q     <= ack_d;
      m_start_q <= m_start_d;
      busy_q    <= busy_d;
`ifdef MULT_ARBITER_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign ack            = ack_q;
  assign product        = product_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign m_start        = m_start_q;
  assign m_multiplicand = mcand_q;
  assign m_multiplier   = mplier_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios followed by randomized traffic, all
// checked against a grant/product reference model and a random-latency multiplier.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef MULT_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_multiplicand, req_multiplier;
  logic [N-1:0]   ack;
  logic [2*W-1:0] product;
  logic [1:0]     grant_id;
  logic           busy, m_start;
  logic [W-1:0]   m_multiplicand, m_multiplier;
  logic           m_rdy;
  logic [2*W-1:0] m_product;
  logic [2:0]     dbg_state;

  mult_arbiter #(.N_REQ(N), .DP_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
    .ack(ack), .product(product), .grant_id(grant_id), .busy(busy),
    .m_start(m_start), .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_rdy(m_rdy), .m_product(m_product), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- multiplier model ----------------
  int             fixed_lat;
  int             lat_used;
  int             mcnt;
  logic [2*W-1:0] pend;

  always @(posedge clk or posedge rst) begin : mul_model
    int l;
    if (rst) begin
      m_rdy     <= 1'b1;
      m_product <= '0;
      mcnt      <= 0;
    end else if (m_start) begin
      l = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
      lat_used <= l;
      mcnt     <= l;
      m_rdy    <= 1'b0;
      pend     <= (2*W)'(m_multiplicand) * (2*W)'(m_multiplier);
    end else if (mcnt != 0) begin
      if (mcnt == 1) begin
        m_rdy     <= 1'b1;
        m_product <= pend;
      end
      mcnt <= mcnt - 1;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int             exp_id_q[$];
  logic [2*W-1:0] exp_q[$];
  int             id_log[$];
  logic [2*W-1:0] prod_log[$];
  int             ptr_m = 0;
  int             ack_cnt = 0;
  int             start_cnt = 0;
  int             cyc = 0;
  int             start_cyc = 0;
  bit             busy_prev = 1'b0;
  bit             m_start_prev = 1'b0;

  // Requester to serve: first raised request at or after start, wrapping.
  function automatic int ref_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Sampled 1 time unit after each rising edge; req/operands are then still the
  // values the design saw on that edge.
  always @(posedge clk) begin : monitor
    int w, eid;
    logic [2*W-1:0] ep;
    #1;
    cyc++;
    if (rst) begin
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_start", m_start, 0);
      chk("rst_product", product, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_m_ops", {m_multiplicand, m_multiplier}, 0);
      exp_id_q.delete();
      exp_q.delete();
      ptr_m        = 0;
      busy_prev    = 1'b0;
      m_start_prev = 1'b0;
    end else begin
      chk("ack_onehot0", $onehot0(ack), 1);
      if (m_start) begin
        chk("m_start_single", m_start_prev, 0);
        start_cyc = cyc;
        start_cnt++;
      end
      if (busy && !busy_prev) begin
        w = ref_pick(req, ptr_m);
        chk("grant_has_req", (w >= 0), 1);
        if (w >= 0) begin
          chk("grant_id", grant_id, w);
          exp_id_q.push_back(w);
          exp_q.push_back((2*W)'(req_multiplicand[w*W +: W]) * (2*W)'(req_multiplier[w*W +: W]));
        end
      end
      if (!busy && !busy_prev) chk("idle_ignored_req", req, 0);
      if (ack != 0) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", ack, 0);
        end else begin
          eid = exp_id_q.pop_front();
          ep  = exp_q.pop_front();
          chk("ack_target", ack, 1 << eid);
          chk("product", product, ep);
          chk("latency", cyc - start_cyc, lat_used + 2);
          id_log.push_back(eid);
          prod_log.push_back(product);
          if (RR) ptr_m = (eid + 1) % N;
        end
        ack_cnt++;
      end
      busy_prev    = busy;
      m_start_prev = m_start;
    end
  end

  // ---------------- driver tasks ----------------
  bit auto_drop = 1'b1;

  task automatic tick();
    @(negedge clk);
    if (auto_drop)
      for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic set_op(input int ch, input logic [W-1:0] a, input logic [W-1:0] b);
    req_multiplicand[ch*W +: W] = a;
    req_multiplier[ch*W +: W]   = b;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((req != 0 || busy) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_in_budget", (c < budget), 1);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int c, base;
    c = 0;
    base = ack_cnt;
    while (ack_cnt < base + n && c < budget) begin
      tick();
      c++;
    end
    chk("acks_in_budget", (ack_cnt >= base + n), 1);
  endtask

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int base, c, s0;
    rst = 1'b1;
    req = '0;
    req_multiplicand = '0;
    req_multiplier   = '0;
    fixed_lat = 3;
    repeat (3) @(negedge clk);
    chk("reset_ack", ack, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    // single request 13*11
    s0 = start_cnt;
    id_log.delete(); prod_log.delete();
    set_op(0, 8'd13, 8'd11);
    req = 4'b0001;
    drain(100);
    chk("single_starts", start_cnt - s0, 1);
    chk("single_acks", id_log.size(), 1);
    if (prod_log.size() > 0) chk("single_product", prod_log[0], 143);

    // four simultaneous requests from a fresh pointer
    reset_dut();
    id_log.delete(); prod_log.delete();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 2), W'(i + 3));
    req = 4'b1111;
    drain(200);
    chk("four_acks", id_log.size(), 4);
    for (int i = 0; i < N; i++)
      if (i < id_log.size()) begin
        chk("four_order", id_log[i], i);
        chk("four_product", prod_log[i], (i + 2) * (i + 3));
      end

    // requesters 0 and 2 held continuously
    reset_dut();
    id_log.delete(); prod_log.delete();
    auto_drop = 1'b0;
    set_op(0, 8'd3, 8'd4);
    set_op(2, 8'd5, 8'd6);
    req = 4'b0101;
    wait_acks(4, 200);
    req = '0;
    auto_drop = 1'b1;
    drain(100);
    for (int i = 0; i < 4; i++)
      if (i < id_log.size()) chk("contend_order", id_log[i], (RR && (i % 2 == 1)) ? 2 : 0);

    // zero operands with a fast multiplier
    reset_dut();
    id_log.delete(); prod_log.delete();
    fixed_lat = 1;
    s0 = ack_cnt;
    set_op(0, 8'd0, 8'd255);
    req = 4'b0001;
    drain(100);
    set_op(3, 8'd255, 8'd0);
    req = 4'b1000;
    drain(100);
    chk("zero_acks", ack_cnt - s0, 2);
    for (int i = 0; i < prod_log.size(); i++) chk("zero_product", prod_log[i], 0);

    // operands and req of the granted channel changed after the grant
    id_log.delete(); prod_log.delete();
    fixed_lat = 4;
    set_op(1, 8'd7, 8'd9);
    req = 4'b0010;
    c = 0;
    while (!busy && c < 20) begin tick(); c++; end
    chk("late_change_granted", busy, 1);
    set_op(1, 8'd100, 8'd100);
    req = '0;
    drain(100);
    c = 0;
    while (id_log.size() == 0 && c < 20) begin tick(); c++; end
    if (prod_log.size() > 0) chk("late_change_product", prod_log[0], 63);
    else chk("late_change_ack", 0, 1);

    // reset in WAIT aborts with no ack
    fixed_lat = 10;
    set_op(2, 8'd3, 8'd5);
    req = 4'b0100;
    c = 0;
    while (!m_start && c < 20) begin tick(); c++; end
    chk("abort_started", m_start, 1);
    repeat (3) tick();
    chk("abort_in_flight", {busy, ack}, 5'b10000);
    base = ack_cnt;
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) tick();
    chk("abort_no_ack", ack_cnt, base);
    chk("abort_outputs", {busy, m_start, grant_id, product, m_multiplicand, m_multiplier}, 0);
    id_log.delete(); prod_log.delete();
    set_op(1, 8'd255, 8'd255);
    req = 4'b0010;
    drain(100);
    if (prod_log.size() > 0) chk("after_abort_product", prod_log[0], 65025);
    else chk("after_abort_ack", 0, 1);

    // randomized traffic
    fixed_lat = 0;
    base = ack_cnt;
    c = 0;
    while (ack_cnt < base + 1000 && c < 40000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, rnd_op(), rnd_op());
          req[i] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          set_op(i, rnd_op(), rnd_op());
        end
      end
      c++;
    end
    chk("random_ops_done", (ack_cnt >= base + 1000), 1);
    drain(500);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DP_WIDTH, default dp_width from the shared package: operand width; product width is 2*DP_WIDTH.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, N_REQ: per-requester level request; bit i is held high until ack[i].
REQ-006 SHALL have port req_multiplicand, input, N_REQ*DP_WIDTH: slice i is the operand of requester i.
REQ-007 SHALL have port req_multiplier, input, N_REQ*DP_WIDTH: slice i is the operand of requester i.
REQ-008 SHALL have port ack, output, N_REQ: one-cycle pulse to the served requester when the result is valid.
REQ-009 SHALL have port product, output, 2*DP_WIDTH: result, valid in the ack cycle and held until the next ack.
REQ-010 SHALL have port grant_id, output, clog2(N_REQ): index of the requester being served.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port m_start, output, 1: one-cycle start pulse to the multiplier.
REQ-013 SHALL have ports m_multiplicand and m_multiplier, outputs, DP_WIDTH each: registered operands, stable from ISSUE until return to IDLE.
REQ-014 SHALL have port m_rdy, input, 1: multiplier ready; it deasserts the cycle after m_start is sampled and reasserts when m_product is valid.
REQ-015 SHALL have port m_product, input, 2*DP_WIDTH: multiplier result.

Function
REQ-016 SHALL implement states IDLE, ISSUE, SETTLE, WAIT, RESP.
REQ-017 IDLE: if any req bit is high, select the winner, latch its index into grant_id and its operands into m_multiplicand and m_multiplier, then go to ISSUE. Otherwise stay in IDLE.
REQ-018 ISSUE: assert m_start for exactly one cycle, then go to SETTLE.
REQ-019 SETTLE: ignore m_rdy for one cycle, then go to WAIT.
REQ-020 WAIT: stay until m_rdy is high. On the cycle m_rdy is sampled high, capture m_product into product and go to RESP.
REQ-021 RESP: pulse ack[grant_id] for one cycle, then go to IDLE. The minimum gap between grants is one IDLE cycle.
REQ-022 Operand changes or a deasserted req on the granted channel after the grant SHALL NOT affect the operation in flight.
REQ-023 New req bits raised while busy SHALL be considered only at the next IDLE.
REQ-024 When several req bits are high in IDLE, exactly one SHALL be granted, per REQ-029 and REQ-030.
REQ-025 A zero operand SHALL be passed unchanged, with no shortcut; the multiplier alone decides latency.
REQ-026 ack SHALL be one-hot or all zero in every cycle.

Reset
REQ-027 While rst is high: state=IDLE, ack=0, m_start=0, busy=0, grant_id=0, product=0, m_multiplicand=0, m_multiplier=0, round-robin pointer=0.
REQ-028 Asserting rst mid-operation SHALL abort the operation with no ack. After release, the block restarts arbitration from IDLE.

Configuration
REQ-029 With MULT_ARBITER_RR_EN defined, arbitration SHALL be round-robin. Search starts at the index after the last granted one, wrapping from N_REQ-1 to 0; the pointer updates in RESP.
REQ-030 Without MULT_ARBITER_RR_EN, arbitration SHALL be fixed priority, lowest index wins, and the pointer logic is absent.

Verification
REQ-031 Single request: req=4'b0001, operands 13 and 11 -> one m_start pulse, ack[0] in the RESP cycle, product=143.
REQ-032 Four simultaneous requests (operands (i+2)*(i+3)), RR build -> grants in order 0,1,2,3, each ack carrying its correct product.
REQ-033 Requester 0 and requester 2 held high continuously, fixed-priority build -> requester 0 always wins and requester 2 starves; RR build -> grants alternate 0,2,0,2.
REQ-034 Zero operand: 0*255 and 255*0 with a fast-finishing multiplier model -> SETTLE is still entered, product=0, one ack.
REQ-035 Reset mid-operation: rst pulsed while in WAIT -> no ack and all outputs return to zero. The next request 255*255 completes with product=65025.
REQ-036 Randomized: 1000 operations with random req and operands and a random-latency multiplier model -> ack one-hot at most, m_start one cycle, every product equals multiplicand*multiplier.
